// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - ALU opcodes, EX state enum and multiplier step count
package ex_pkg;

  localparam int MUL_STEPS = 64;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_PASA = 4'd9;
  localparam logic [3:0] OP_PASB = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_e;

  // Fields carried alongside a multiply while it iterates
  typedef struct packed {
    logic [63:0] rt_data;
    logic [1:0]  rd;
    logic [7:0]  address;
    logic        wreg_en;
    logic        wmem_en;
    logic        mem_to_reg;
  } ex_fields_t;

endpackage

// File: rtl/iter_mul64.sv
// rtl/iter_mul64.sv - 64x64 shift-add multiplier, one multiplier bit per cycle
module iter_mul64
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  logic [63:0] acc;
  logic [63:0] a_sh;
  logic [63:0] b_sh;
  logic [5:0]  cnt;
  logic [63:0] acc_step;

  // Partial sum after this cycle's step; the final step's value is the product
  always_comb begin
    acc_step = acc + (b_sh[0] ? a_sh : 64'd0);
  end

  assign product = acc_step;
  assign done    = busy && (cnt == 6'(MUL_STEPS - 1));

  // Load operands on start, then consume one multiplier bit per edge
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= 6'd0;
      acc  <= 64'd0;
      a_sh <= 64'd0;
      b_sh <= 64'd0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= 6'd0;
      acc  <= 64'd0;
      a_sh <= a;
      b_sh <= b;
    end else if (busy) begin
      acc  <= acc_step;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 6'd1;
      if (cnt == 6'(MUL_STEPS - 1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU plus iterative MUL with stall
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rs_data_in,
  input  logic [63:0] rt_data_in,
  input  logic [1:0]  rd_in,
  input  logic [7:0]  address_in,
  input  logic        WRegEn_in,
  input  logic        WMemEn_in,
  input  logic        MemToReg_in,
  input  logic [3:0]  ALUOp_in,
  input  logic        flush,
  output logic [63:0] alu_result_out,
  output logic [63:0] rt_data_out,
  output logic [1:0]  rd_out,
  output logic [7:0]  address_out,
  output logic        WRegEn_out,
  output logic        WMemEn_out,
  output logic        MemToReg_out,
  output logic        stall_out
);

  ex_state_e   state;
  logic [5:0]  count;
  ex_fields_t  held;
  ex_fields_t  in_fields;
  logic [63:0] alu_comb;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_product;

  assign in_fields = '{rt_data: rt_data_in, rd: rd_in, address: address_in,
                       wreg_en: WRegEn_in, wmem_en: WMemEn_in,
                       mem_to_reg: MemToReg_in};

  // Single-cycle result select; MUL and unused codes yield 0 here
  always_comb begin
    alu_comb = 64'd0;
    case (ALUOp_in)
      OP_ADD:  alu_comb = rs_data_in + rt_data_in;
      OP_SUB:  alu_comb = rs_data_in - rt_data_in;
      OP_AND:  alu_comb = rs_data_in & rt_data_in;
      OP_OR:   alu_comb = rs_data_in | rt_data_in;
      OP_XOR:  alu_comb = rs_data_in ^ rt_data_in;
      OP_NOT:  alu_comb = ~rs_data_in;
      OP_SLL:  alu_comb = rs_data_in << rt_data_in[5:0];
      OP_SRL:  alu_comb = rs_data_in >> rt_data_in[5:0];
      OP_SLT:  alu_comb = ($signed(rs_data_in) < $signed(rt_data_in)) ? 64'd1 : 64'd0;
      OP_PASA: alu_comb = rs_data_in;
      OP_PASB: alu_comb = rt_data_in;
      default: alu_comb = 64'd0;
    endcase
  end

  // The multiplier is cleared by flush as well, so an aborted MUL leaves nothing behind
  assign mul_start = (state == IDLE) && (ALUOp_in == OP_MUL) && !mul_busy && !flush;

  iter_mul64 u_mul (
    .clk     (clk),
    .reset   (reset || flush),
    .start   (mul_start),
    .a       (rs_data_in),
    .b       (rt_data_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // State, step count and the whole EX_MEM-facing output register
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state          <= IDLE;
      count          <= 6'd0;
      held           <= '0;
      alu_result_out <= 64'd0;
      rt_data_out    <= 64'd0;
      rd_out         <= 2'd0;
      address_out    <= 8'd0;
      WRegEn_out     <= 1'b0;
      WMemEn_out     <= 1'b0;
      MemToReg_out   <= 1'b0;
      stall_out      <= 1'b0;
    end else if (state == IDLE) begin
      if (mul_start) begin
        state          <= BUSY;
        count          <= 6'd0;
        held           <= in_fields;
        stall_out      <= 1'b1;
        alu_result_out <= 64'd0;
        rt_data_out    <= 64'd0;
        rd_out         <= 2'd0;
        address_out    <= 8'd0;
        WRegEn_out     <= 1'b0;
        WMemEn_out     <= 1'b0;
        MemToReg_out   <= 1'b0;
      end else begin
        stall_out      <= 1'b0;
        alu_result_out <= alu_comb;
        rt_data_out    <= rt_data_in;
        rd_out         <= rd_in;
        address_out    <= address_in;
        WRegEn_out     <= WRegEn_in;
        WMemEn_out     <= WMemEn_in;
        MemToReg_out   <= MemToReg_in;
      end
    end else begin
      if (count == 6'(MUL_STEPS - 1) && mul_done) begin
        state          <= IDLE;
        count          <= 6'd0;
        stall_out      <= 1'b0;
        alu_result_out <= mul_product;
        rt_data_out    <= held.rt_data;
        rd_out         <= held.rd;
        address_out    <= held.address;
        WRegEn_out     <= held.wreg_en;
        WMemEn_out     <= held.wmem_en;
        MemToReg_out   <= held.mem_to_reg;
      end else begin
        count          <= count + 6'd1;
        stall_out      <= 1'b1;
        alu_result_out <= 64'd0;
        rt_data_out    <= 64'd0;
        rd_out         <= 2'd0;
        address_out    <= 8'd0;
        WRegEn_out     <= 1'b0;
        WMemEn_out     <= 1'b0;
        MemToReg_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] rs_data_in, rt_data_in;
  logic [1:0]  rd_in;
  logic [7:0]  address_in;
  logic        WRegEn_in, WMemEn_in, MemToReg_in;
  logic [3:0]  ALUOp_in;
  logic        flush;
  logic [63:0] alu_result_out, rt_data_out;
  logic [1:0]  rd_out;
  logic [7:0]  address_out;
  logic        WRegEn_out, WMemEn_out, MemToReg_out, stall_out;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .rd_in(rd_in),
    .address_in(address_in), .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in),
    .MemToReg_in(MemToReg_in), .ALUOp_in(ALUOp_in), .flush(flush),
    .alu_result_out(alu_result_out), .rt_data_out(rt_data_out), .rd_out(rd_out),
    .address_out(address_out), .WRegEn_out(WRegEn_out), .WMemEn_out(WMemEn_out),
    .MemToReg_out(MemToReg_out), .stall_out(stall_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[14];

  // Reference: what each opcode means arithmetically
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] full;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return a << b[5:0];
      4'd7:  return a >> b[5:0];
      4'd8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9:  return a;
      4'd10: return b;
      4'd11: begin full = {64'd0, a} * {64'd0, b}; return full[63:0]; end
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] rd, input logic [7:0] addr, input logic [2:0] ctl);
    ALUOp_in = op; rs_data_in = a; rt_data_in = b; rd_in = rd; address_in = addr;
    {WRegEn_in, WMemEn_in, MemToReg_in} = ctl;
  endtask

  function automatic logic [63:0] any_out();
    return {63'd0, |{alu_result_out, rt_data_out, rd_out, address_out,
                     WRegEn_out, WMemEn_out, MemToReg_out, stall_out}};
  endfunction

  function automatic logic [63:0] bubble_bad();
    return {63'd0, |{alu_result_out, rt_data_out, rd_out, address_out,
                     WRegEn_out, WMemEn_out, MemToReg_out}};
  endfunction

  // Present a single-cycle op and check result and pass-through one edge later
  task automatic single(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    logic [1:0] rd;
    logic [7:0] addr;
    logic [2:0] ctl;
    rd = 2'($urandom); addr = 8'($urandom); ctl = 3'($urandom);
    drive(op, a, b, rd, addr, ctl);
    step();
    check({name, ".res"}, alu_result_out, exp);
    check({name, ".pass"}, {rt_data_out[60:0], rd_out, address_out[0], 1'b0},
          {b[60:0], rd, addr[0], 1'b0});
    check({name, ".ctl"}, {56'd0, address_out, 1'b0},
          {56'd0, addr, 1'b0});
    check({name, ".flags"}, {60'd0, WRegEn_out, WMemEn_out, MemToReg_out, stall_out},
          {60'd0, ctl, 1'b0});
  endtask

  // Run a MUL, count stall cycles with a bound, check product and latched fields
  task automatic run_mul(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] rd, input logic [2:0] ctl);
    int n;
    logic bub_err;
    drive(4'd11, a, b, rd, 8'h5A, ctl);
    step();
    drive(4'd0, 64'd5, 64'd7, 2'd1, 8'h11, 3'b100);
    n = 0;
    bub_err = 1'b0;
    while (stall_out && n < 100) begin
      if (bubble_bad() != 0) bub_err = 1'b1;
      n++;
      step();
    end
    check({name, ".stalls"}, 64'(n), 64'd64);
    check({name, ".bubble"}, {63'd0, bub_err}, 64'd0);
    check({name, ".prod"}, alu_result_out, ref_alu(4'd11, a, b));
    check({name, ".rd"}, {60'd0, rd_out, address_out[1:0]}, {60'd0, rd, 2'b10});
    check({name, ".ctl"}, {61'd0, WRegEn_out, WMemEn_out, MemToReg_out}, {61'd0, ctl});
    check({name, ".rt"}, rt_data_out, b);
  endtask

  initial begin
    logic [63:0] a, b;
    logic [3:0]  op;
    logic        err;

    tbl[0]  = '{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    tbl[1]  = '{4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
    tbl[2]  = '{4'd7,  64'h8000_0000_0000_0000, 64'd63, 64'd1};
    tbl[3]  = '{4'd13, 64'h1234, 64'h5678, 64'd0};
    tbl[4]  = '{4'd1,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5]  = '{4'd2,  64'hF0F0, 64'hFF00, 64'hF000};
    tbl[6]  = '{4'd3,  64'hF0F0, 64'h0F0F, 64'hFFFF};
    tbl[7]  = '{4'd4,  64'hFFFF, 64'h0F0F, 64'hF0F0};
    tbl[8]  = '{4'd5,  64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[9]  = '{4'd6,  64'd1, 64'h1_0000_0043, 64'd8};
    tbl[10] = '{4'd9,  64'hABCD, 64'd1, 64'hABCD};
    tbl[11] = '{4'd10, 64'hABCD, 64'h77, 64'h77};
    tbl[12] = '{4'd8,  64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    tbl[13] = '{4'd15, 64'hFFFF, 64'hFFFF, 64'd0};

    reset = 1'b1; flush = 1'b0;
    drive(4'd0, 64'd3, 64'd4, 2'd3, 8'hFF, 3'b111);
    step(); step();
    check("reset.outputs", any_out(), 64'd0);
    reset = 1'b0;

    foreach (tbl[i]) single($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd11) op = 4'd12;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      single($sformatf("rnd%0d", i), op, a, b, ref_alu(op, a, b));
    end

    // Directed MUL with ADD held upstream; ADD must land on the following edge
    run_mul("mul_dir", 64'h1_0000_0001, 64'd3, 2'd2, 3'b100);
    check("mul_dir.val", alu_result_out, 64'h3_0000_0003);
    step();
    check("held_add", alu_result_out, 64'd12);
    check("held_add.rd", {62'd0, rd_out}, 64'd1);

    // Back-to-back random MULs
    for (int i = 0; i < 3; i++) begin
      run_mul($sformatf("mul_rnd%0d", i), {$urandom, $urandom}, {$urandom, $urandom},
              2'($urandom), 3'($urandom));
    end

    // Flush at count=30: bubble, stall drops, product never appears
    drive(4'd11, 64'h1_0000_0001, 64'd3, 2'd2, 8'h01, 3'b100);
    step();
    drive(4'd12, 64'd0, 64'd0, 2'd0, 8'd0, 3'b000);
    for (int i = 0; i < 30; i++) step();
    check("pre_flush.stall", {63'd0, stall_out}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush.outputs", any_out(), 64'd0);
    err = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (any_out() != 0) err = 1'b1;
    end
    check("flush.no_result", {63'd0, err}, 64'd0);

    // Reset mid-BUSY discards the multiply
    drive(4'd11, 64'd9, 64'd9, 2'd3, 8'h22, 3'b111);
    step();
    drive(4'd12, 64'd0, 64'd0, 2'd0, 8'd0, 3'b000);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy.outputs", any_out(), 64'd0);
    err = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (any_out() != 0) err = 1'b1;
    end
    check("rst_busy.no_result", {63'd0, err}, 64'd0);

    // Reset coinciding with an ADD
    drive(4'd0, 64'd5, 64'd7, 2'd1, 8'h33, 3'b111);
    reset = 1'b1;
    step();
    check("rst_add.outputs", any_out(), 64'd0);
    reset = 1'b0;
    step();
    check("after_rst_add", alu_result_out, 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- rs_data_in  in  64  operand A, from ID_EX rs_data_out
- rt_data_in  in  64  operand B and store data, from ID_EX rt_data_out
- rd_in  in  2  destination register index
- address_in  in  8  data-memory address
- WRegEn_in  in  1  register write enable
- WMemEn_in  in  1  memory write enable
- MemToReg_in  in  1  writeback select
- ALUOp_in  in  4  operation code
- flush  in  1  squash the instruction in EX
- alu_result_out  out  64  registered result for EX_MEM
- rt_data_out  out  64  registered store data
- rd_out  out  2  registered rd
- address_out  out  8  registered address
- WRegEn_out  out  1  registered control
- WMemEn_out  out  1  registered control
- MemToReg_out  out  1  registered control
- stall_out  out  1  upstream holds ID_EX while high

Function
REQ-002 ALUOp encodings SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT rs, 6 SLL rs by rt[5:0], 7 SRL rs by rt[5:0], 8 SLT signed (result 64'd1 or 64'd0), 9 PASS rs, 10 PASS rt, 11 MUL. Codes 12-15 SHALL produce result 0, with controls passed through unchanged.
REQ-003 ADD/SUB/MUL SHALL wrap modulo 2^64. MUL SHALL return the low 64 bits of the unsigned product. No carry or overflow is reported.
REQ-004 Single-cycle ops SHALL have 1-cycle latency: at the edge after the inputs are presented, all outputs SHALL carry the result and the passed-through rt_data, rd, address and controls.
REQ-005 The FSM SHALL have two states, IDLE and BUSY, and a 6-bit step counter.
REQ-006 IDLE with ALUOp_in=MUL: at the next edge, latch the operands, rd, address and controls; go to BUSY with count=0; write a bubble to the outputs.
REQ-007 BUSY: one shift-add step per edge. At the edge where count=63, write the product and the latched fields to the outputs, then return to IDLE. Otherwise increment count and write a bubble.
REQ-008 Bubble SHALL mean WRegEn_out=WMemEn_out=MemToReg_out=0 and all data outputs 0.
REQ-009 stall_out SHALL be registered and equal (state==BUSY). It is low in the cycle a MUL is first presented, so exactly 64 stall cycles follow the MUL capture edge.
REQ-010 ID_EX inputs SHALL be ignored while BUSY. The instruction held upstream SHALL execute in the first IDLE cycle after stall_out falls.
REQ-011 flush=1 at an edge SHALL write a bubble, abort any MUL in progress, go to IDLE and clear count. flush takes priority over REQ-004/006/007.
REQ-012 Back-to-back MULs SHALL each take the full sequence. No forwarding or hazard detection is performed in this block.

Reset
REQ-013 reset=1 at an edge SHALL force all outputs to 0, stall_out=0, state IDLE and count=0.
REQ-014 Priority SHALL be reset > flush > normal operation.
REQ-015 Reset during BUSY SHALL discard the multiply with no output write.

Structure
REQ-016 Package ex_pkg SHALL hold the ALUOp encodings, the state enum, and MUL_STEPS=64.
REQ-017 The multiplier SHALL be a sub-module iter_mul64: start, a, b in; busy, done, product out; one bit per cycle.
REQ-018 The output register SHALL be a single registered block; result muxing is combinational.

Verification
REQ-019 ADD rs=0xFFFF_FFFF_FFFF_FFFF, rt=1 -> next cycle alu_result_out=0 with controls passed through.
REQ-020 SLT rs=-1, rt=0 -> 1; SRL rs=0x8000_0000_0000_0000, rt=63 -> 1; ALUOp=13 -> 0.
REQ-021 MUL rs=0x1_0000_0001, rt=3, rd=2, WRegEn=1 -> stall_out high 64 cycles, outputs bubble, then alu_result_out=0x3_0000_0003 with rd_out=2 and WRegEn_out=1 in the cycle stall_out falls.
REQ-022 MUL followed by ADD 5+7 held upstream -> ADD result 12 appears exactly one cycle after the MUL result.
REQ-023 flush at count=30 of a MUL -> bubble, stall_out low next cycle, no MUL result ever written.
REQ-024 reset mid-BUSY and mid-ADD -> all outputs 0 and stall_out 0 at the next cycle.
